// File: rtl/execute_stage_if.sv
// Decode->execute pipeline bus: the control word and operands come in, and the
// registered execute->memory copies plus the N/Z flags go back out.
interface execute_stage_if #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 4
);
  logic              stall;
  logic              flush;
  logic              wbs_in;
  logic              wme_in;
  logic [1:0]        mm_in;
  logic [2:0]        ALUop_in;
  logic              wm_in;
  logic              am_in;
  logic              ni_in;
  logic [WIDTH-1:0]  srcA_in;
  logic [WIDTH-1:0]  srcB_in;
  logic [REG_AW-1:0] rd_in;
  logic [WIDTH-1:0]  store_data_in;

  logic              flagN;
  logic              flagZ;
  logic              valid_out;
  logic              wbs_out;
  logic              wme_out;
  logic [1:0]        mm_out;
  logic              wm_out;
  logic [REG_AW-1:0] rd_out;
  logic [WIDTH-1:0]  alu_result_out;
  logic [WIDTH-1:0]  store_data_out;

  modport master (
    output stall, flush, wbs_in, wme_in, mm_in, ALUop_in, wm_in, am_in, ni_in,
           srcA_in, srcB_in, rd_in, store_data_in,
    input  flagN, flagZ, valid_out, wbs_out, wme_out, mm_out, wm_out, rd_out,
           alu_result_out, store_data_out
  );

  modport slave (
    input  stall, flush, wbs_in, wme_in, mm_in, ALUop_in, wm_in, am_in, ni_in,
           srcA_in, srcB_in, rd_in, store_data_in,
    output flagN, flagZ, valid_out, wbs_out, wme_out, mm_out, wm_out, rd_out,
           alu_result_out, store_data_out
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: 16-bit ALU, N/Z flag register and the execute->memory pipeline
// register, with flush > stall > normal priority on every rising edge.
module execute_stage #(
  parameter int WIDTH   = 16,
  parameter int REG_AW  = 4,
  parameter int SHAMT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  execute_stage_if.slave  pipe
);

  logic [WIDTH-1:0]   alu_result_d;
  logic [SHAMT_W-1:0] shamt;
  logic               bubble_d;
  logic               take_d;

  logic               flag_n_q;
  logic               flag_z_q;
  logic               valid_q;
  logic               wbs_q;
  logic               wme_q;
  logic [1:0]         mm_q;
  logic               wm_q;
  logic [REG_AW-1:0]  rd_q;
  logic [WIDTH-1:0]   alu_result_q;
  logic [WIDTH-1:0]   store_data_q;

  assign shamt = pipe.srcB_in[SHAMT_W-1:0];

  always_comb begin
    alu_result_d = '0;
    unique case (pipe.ALUop_in)
      3'b000:  alu_result_d = pipe.srcA_in + pipe.srcB_in;
      3'b001:  alu_result_d = pipe.srcA_in - pipe.srcB_in;
      3'b010:  alu_result_d = pipe.srcA_in & pipe.srcB_in;
      3'b011:  alu_result_d = pipe.srcA_in | pipe.srcB_in;
      3'b100:  alu_result_d = pipe.srcA_in ^ pipe.srcB_in;
      3'b101:  alu_result_d = pipe.srcA_in << shamt;
      3'b110:  alu_result_d = pipe.srcA_in >> shamt;
      default: alu_result_d = pipe.srcB_in;
    endcase
  end

  // A bubble is loaded on flush, or on an unstalled edge whose slot is empty.
  assign bubble_d = pipe.flush | (~pipe.stall & pipe.ni_in);
  assign take_d   = ~pipe.flush & ~pipe.stall & ~pipe.ni_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_n_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      valid_q      <= 1'b0;
      wbs_q        <= 1'b0;
      wme_q        <= 1'b0;
      mm_q         <= '0;
      wm_q         <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
    end else begin
      if (bubble_d) begin
        valid_q      <= 1'b0;
        wbs_q        <= 1'b0;
        wme_q        <= 1'b0;
        mm_q         <= '0;
        wm_q         <= 1'b0;
        rd_q         <= '0;
        alu_result_q <= '0;
        store_data_q <= '0;
      end else if (take_d) begin
        valid_q      <= 1'b1;
        wbs_q        <= pipe.wbs_in;
        wme_q        <= pipe.wme_in;
        mm_q         <= pipe.mm_in;
        wm_q         <= pipe.wm_in;
        rd_q         <= pipe.rd_in;
        alu_result_q <= alu_result_d;
        store_data_q <= pipe.store_data_in;
      end
      if (take_d && pipe.am_in) begin
        flag_n_q <= alu_result_d[WIDTH-1];
        flag_z_q <= (alu_result_d == '0);
      end
    end
  end

  assign pipe.flagN          = flag_n_q;
  assign pipe.flagZ          = flag_z_q;
  assign pipe.valid_out      = valid_q;
  assign pipe.wbs_out        = wbs_q;
  assign pipe.wme_out        = wme_q;
  assign pipe.mm_out         = mm_q;
  assign pipe.wm_out         = wm_q;
  assign pipe.rd_out         = rd_q;
  assign pipe.alu_result_out = alu_result_q;
  assign pipe.store_data_out = store_data_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: arithmetic reference model compared every cycle,
// plus directed vectors with literal expected values.
module tb_execute_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   cmp_en;

  execute_stage_if #(.WIDTH(16), .REG_AW(4)) bus ();

  execute_stage #(.WIDTH(16), .REG_AW(4), .SHAMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pipe  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic.
  function automatic int ref_alu(input int op, input int a, input int b);
    int s;
    s = b % 16;
    case (op)
      0: return (a + b) % 65536;
      1: return (a - b + 65536) % 65536;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a * (1 << s)) % 65536;
      6: return a / (1 << s);
      default: return b;
    endcase
  endfunction

  int m_res, m_store, m_rd, m_mm;
  bit m_valid, m_wbs, m_wme, m_wm, m_n, m_z;

  always @(posedge clk or negedge rst_n) begin
    int r;
    if (!rst_n) begin
      m_res <= 0; m_store <= 0; m_rd <= 0; m_mm <= 0;
      m_valid <= 0; m_wbs <= 0; m_wme <= 0; m_wm <= 0; m_n <= 0; m_z <= 0;
    end else if (bus.flush || (!bus.stall && bus.ni_in)) begin
      m_res <= 0; m_store <= 0; m_rd <= 0; m_mm <= 0;
      m_valid <= 0; m_wbs <= 0; m_wme <= 0; m_wm <= 0;
    end else if (!bus.stall) begin
      r = ref_alu(int'(bus.ALUop_in), int'(bus.srcA_in), int'(bus.srcB_in));
      m_res   <= r;
      m_store <= int'(bus.store_data_in);
      m_rd    <= int'(bus.rd_in);
      m_mm    <= int'(bus.mm_in);
      m_valid <= 1;
      m_wbs   <= bus.wbs_in;
      m_wme   <= bus.wme_in;
      m_wm    <= bus.wm_in;
      if (bus.am_in) begin
        m_n <= (r >= 32768);
        m_z <= (r == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_result", 32'(bus.alu_result_out), 32'(m_res));
      chk("m_store",  32'(bus.store_data_out), 32'(m_store));
      chk("m_rd",     32'(bus.rd_out),         32'(m_rd));
      chk("m_mm",     32'(bus.mm_out),         32'(m_mm));
      chk("m_valid",  32'(bus.valid_out),      32'(m_valid));
      chk("m_wbs",    32'(bus.wbs_out),        32'(m_wbs));
      chk("m_wme",    32'(bus.wme_out),        32'(m_wme));
      chk("m_wm",     32'(bus.wm_out),         32'(m_wm));
      chk("m_flagN",  32'(bus.flagN),          32'(m_n));
      chk("m_flagZ",  32'(bus.flagZ),          32'(m_z));
    end
  end

  task automatic randomize_inputs();
    bus.stall         = 1'($urandom_range(0, 1));
    bus.flush         = 1'($urandom_range(0, 1));
    bus.wbs_in        = 1'($urandom_range(0, 1));
    bus.wme_in        = 1'($urandom_range(0, 1));
    bus.mm_in         = 2'($urandom_range(0, 3));
    bus.ALUop_in      = 3'($urandom_range(0, 7));
    bus.wm_in         = 1'($urandom_range(0, 1));
    bus.am_in         = 1'($urandom_range(0, 1));
    bus.ni_in         = 1'($urandom_range(0, 1));
    bus.srcA_in       = 16'($urandom);
    bus.srcB_in       = 16'($urandom);
    bus.rd_in         = 4'($urandom_range(0, 15));
    bus.store_data_in = 16'($urandom);
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.wbs_in = 0; bus.wme_in = 0; bus.mm_in = 0;
    bus.ALUop_in = 0; bus.wm_in = 0; bus.am_in = 0; bus.ni_in = 1;
    bus.srcA_in = 0; bus.srcB_in = 0; bus.rd_in = 0; bus.store_data_in = 0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd, input logic wm, input logic am);
    idle();
    bus.ni_in = 0;
    bus.ALUop_in = op; bus.srcA_in = a; bus.srcB_in = b;
    bus.rd_in = rd; bus.wm_in = wm; bus.am_in = am;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    randomize_inputs();
    #2 cmp_en = 1'b1;

    // Reset with busy inputs.
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid",  32'(bus.valid_out), 32'h0);
      chk("rst_result", 32'(bus.alu_result_out), 32'h0);
      randomize_inputs();
    end
    idle();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_valid",  32'(bus.valid_out), 32'h0);
    chk("idle_result", 32'(bus.alu_result_out), 32'h0);

    // mov with pass-through fields.
    drive(3'b111, 16'h1234, 16'h0007, 4'd1, 1'b1, 1'b1);
    bus.store_data_in = 16'hABCD; bus.mm_in = 2'd2; bus.wbs_in = 1; bus.wme_in = 1;
    tick();
    chk("mov_result", 32'(bus.alu_result_out), 32'h7);
    chk("mov_rd",     32'(bus.rd_out), 32'h1);
    chk("mov_wm",     32'(bus.wm_out), 32'h1);
    chk("mov_valid",  32'(bus.valid_out), 32'h1);
    chk("mov_N",      32'(bus.flagN), 32'h0);
    chk("mov_Z",      32'(bus.flagZ), 32'h0);
    chk("mov_store",  32'(bus.store_data_out), 32'hABCD);
    chk("mov_mm",     32'(bus.mm_out), 32'h2);

    drive(3'b000, 16'd7, 16'd9, 4'd2, 1'b1, 1'b1);
    tick();
    chk("add_result", 32'(bus.alu_result_out), 32'd16);

    drive(3'b001, 16'd7, 16'd7, 4'd2, 1'b1, 1'b1);
    tick();
    chk("sub0_result", 32'(bus.alu_result_out), 32'd0);
    chk("sub0_Z",      32'(bus.flagZ), 32'h1);

    drive(3'b001, 16'd7, 16'd9, 4'd2, 1'b1, 1'b1);
    tick();
    chk("subneg_result", 32'(bus.alu_result_out), 32'hFFFE);
    chk("subneg_N",      32'(bus.flagN), 32'h1);
    chk("subneg_Z",      32'(bus.flagZ), 32'h0);

    drive(3'b001, 16'd7, 16'd7, 4'd2, 1'b1, 1'b0);
    tick();
    chk("am0_result", 32'(bus.alu_result_out), 32'h0);
    chk("am0_N",      32'(bus.flagN), 32'h1);
    chk("am0_Z",      32'(bus.flagZ), 32'h0);

    drive(3'b101, 16'h8001, 16'h0011, 4'd3, 1'b1, 1'b0);
    tick();
    chk("shl_result", 32'(bus.alu_result_out), 32'h0002);
    drive(3'b110, 16'h8001, 16'h0011, 4'd3, 1'b1, 1'b0);
    tick();
    chk("shr_result", 32'(bus.alu_result_out), 32'h4000);

    // Stall holds everything while inputs move.
    drive(3'b000, 16'd1, 16'd2, 4'd3, 1'b1, 1'b1);
    tick();
    chk("pre_stall_result", 32'(bus.alu_result_out), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 16'(i), 16'd100, 4'd9, 1'b0, 1'b1);
      bus.stall = 1;
      tick();
      chk("stall_result", 32'(bus.alu_result_out), 32'd3);
      chk("stall_rd",     32'(bus.rd_out), 32'd3);
      chk("stall_N",      32'(bus.flagN), 32'h0);
    end
    drive(3'b100, 16'h00F0, 16'h0F0F, 4'd5, 1'b1, 1'b1);
    tick();
    chk("unstall_result", 32'(bus.alu_result_out), 32'h0FFF);

    // Flush beats stall; flags keep the pre-flush value.
    drive(3'b000, 16'h8000, 16'h8000, 4'd6, 1'b1, 1'b1);
    bus.stall = 1; bus.flush = 1; bus.wme_in = 1;
    tick();
    chk("flush_valid",  32'(bus.valid_out), 32'h0);
    chk("flush_wme",    32'(bus.wme_out), 32'h0);
    chk("flush_wm",     32'(bus.wm_out), 32'h0);
    chk("flush_result", 32'(bus.alu_result_out), 32'h0);
    chk("flush_Z",      32'(bus.flagZ), 32'h0);

    drive(3'b000, 16'h8000, 16'h8000, 4'd6, 1'b1, 1'b1);
    bus.ni_in = 1; bus.wme_in = 1;
    tick();
    chk("ni_valid", 32'(bus.valid_out), 32'h0);
    chk("ni_wme",   32'(bus.wme_out), 32'h0);
    chk("ni_wm",    32'(bus.wm_out), 32'h0);
    chk("ni_Z",     32'(bus.flagZ), 32'h0);

    // Mixed traffic, mostly normal edges, checked by the model.
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.ni_in = ($urandom_range(0, 5) == 0);
      tick();
    end

    // Reset mid-operation clears the in-flight instruction.
    drive(3'b111, 16'h0, 16'h5555, 4'd7, 1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid",  32'(bus.valid_out), 32'h0);
    chk("midrst_result", 32'(bus.alu_result_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
